multdiv_param: RTL

MULTDIV_PARAM -- requirements
Module: multdiv_param

---
 rtl/multdiv_param.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multdiv_param.sv
// Iterative multiplier/divider: shift-add multiply and restoring divide on operand magnitudes,
// with sign correction and exception flagging applied on the final RUN cycle.
module multdiv_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div, r_sgn, r_neg_q, r_neg_r, r_bad, r_dz, r_ovf;
  logic [WIDTH-1:0] r_b, r_hi, r_lo;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic             r_exc;

  logic             w_start, w_both, w_last, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_sum, w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0] w_fin_res, w_fin_hi;
  logic             w_fin_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_both  = ctrl_MULT & ctrl_DIV;
  assign w_last  = (r_state == StRun) && (r_cnt == CW'(WIDTH));
  assign w_a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
  assign w_b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
  assign w_mag_a = w_a_neg ? -data_operandA : data_operandA;
  assign w_mag_b = w_b_neg ? -data_operandB : data_operandB;

  // Multiply step: conditionally add multiplicand into the high half, then shift right.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Divide step: partial remainder stays below the divisor, so a WIDTH-bit difference suffices.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_b};
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

  assign w_prod_s = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};

  always_comb begin
    w_fin_res = '0;
    w_fin_hi  = '0;
    w_fin_exc = 1'b0;
    if (r_bad) begin
      w_fin_exc = 1'b1;
    end else if (!r_is_div) begin
      w_fin_res = w_prod_s[WIDTH-1:0];
      w_fin_hi  = w_prod_s[2*WIDTH-1:WIDTH];
      w_fin_exc = r_sgn ? (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}})
                        : (w_prod_s[2*WIDTH-1:WIDTH] != '0);
    end else if (r_dz) begin
      w_fin_exc = 1'b1;
    end else begin
      // Most-negative / -1 yields MinNeg naturally from the magnitude path.
      w_fin_res = r_neg_q ? -r_lo : r_lo;
      w_fin_hi  = r_neg_r ? -r_hi : r_hi;
      w_fin_exc = r_ovf;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StRun;
      StRun:   if (w_start) w_state_d = StRun;
               else if (w_last) w_state_d = StDone;
      StDone:  w_state_d = w_start ? StRun : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sgn    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bad    <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      // Both strobes: skip iteration so the final cycle follows immediately.
      r_cnt    <= w_both ? CW'(WIDTH) : '0;
      r_bad    <= w_both;
      r_is_div <= ctrl_DIV;
      r_sgn    <= ctrl_SIGNED;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dz     <= (data_operandB == '0);
      r_ovf    <= ctrl_SIGNED && (data_operandA == MinNeg) && (data_operandB == '1);
      r_b      <= ctrl_DIV ? w_mag_b : w_mag_a;
      r_lo     <= ctrl_DIV ? w_mag_a : w_mag_b;
      r_hi     <= '0;
    end else if (r_state == StRun) begin
      if (w_last) begin
        r_res    <= w_fin_res;
        r_res_hi <= w_fin_hi;
        r_exc    <= w_fin_exc;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_hi <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], w_ge};
        end else begin
          r_hi <= w_sum[WIDTH:1];
          r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
        end
      end
    end
  end

  assign data_result    = r_res;
  assign data_result_hi = r_res_hi;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == StDone);
  assign busy           = (r_state == StRun);

endmodule
